// File: rtl/lms_err_monitor.sv
// Mean-square-error convergence monitor for the LMS filter error output.
// Optional peak-|err| tracking is enabled by defining LMS_PEAK_HOLD_EN.
module lms_err_monitor #(
    parameter int ERR_WIDTH = 14,
    parameter int LOG2_WIN  = 8,
    parameter int CONV_CNT  = 4,
    parameter int DIV_CNT   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        clear,
    input  logic                        err_valid,
    input  logic signed [ERR_WIDTH-1:0] err,
    input  logic [2*ERR_WIDTH-2:0]      mse_thresh,
    output logic [2*ERR_WIDTH-2:0]      mse,
    output logic                        mse_valid,
    output logic                        converged,
    output logic [15:0]                 win_cnt,
    output logic [ERR_WIDTH-1:0]        err_peak
);

    localparam int SQ_W  = 2*ERR_WIDTH-1;
    localparam int ACC_W = SQ_W+LOG2_WIN;
    localparam int BW    = $clog2(CONV_CNT+1);
    localparam int DW    = $clog2(DIV_CNT+1);

    typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

    state_t                state;
    logic [ACC_W-1:0]      acc;
    logic [LOG2_WIN-1:0]   smp_cnt;
    logic [SQ_W-1:0]       sq;
    logic                  sq_valid;
    logic [BW-1:0]         below_cnt;
    logic [DW-1:0]         above_cnt;

    logic [ERR_WIDTH-1:0]  abs_err;
    logic [SQ_W-1:0]       sq_next;
    logic [SQ_W-1:0]       mse_next;
    logic [BW-1:0]         below_inc;
    logic [DW-1:0]         above_inc;

    // Squaring the magnitude keeps every product bit meaningful; 2^(ERR_WIDTH-1) squared fits SQ_W.
    always_comb begin
        abs_err   = err[ERR_WIDTH-1] ? (~$unsigned(err) + 1'b1) : $unsigned(err);
        sq_next   = SQ_W'(abs_err) * SQ_W'(abs_err);
        mse_next  = acc[ACC_W-1:LOG2_WIN];
        below_inc = (below_cnt == BW'(CONV_CNT)) ? below_cnt : below_cnt + 1'b1;
        above_inc = (above_cnt == DW'(DIV_CNT))  ? above_cnt : above_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            smp_cnt   <= '0;
            sq        <= '0;
            sq_valid  <= 1'b0;
            below_cnt <= '0;
            above_cnt <= '0;
            mse       <= '0;
            mse_valid <= 1'b0;
            converged <= 1'b0;
            win_cnt   <= '0;
        end else if (!en) begin
            state     <= IDLE;
            acc       <= '0;
            smp_cnt   <= '0;
            sq_valid  <= 1'b0;
            mse_valid <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            smp_cnt   <= '0;
            sq_valid  <= 1'b0;
            below_cnt <= '0;
            above_cnt <= '0;
            converged <= 1'b0;
            mse_valid <= 1'b0;
        end else begin
            mse_valid <= 1'b0;
            sq_valid  <= err_valid;
            if (err_valid)
                sq <= sq_next;
            case (state)
                IDLE: state <= ACCUM;
                ACCUM: begin
                    if (sq_valid) begin
                        acc     <= acc + ACC_W'(sq);
                        smp_cnt <= smp_cnt + 1'b1;
                        if (smp_cnt == '1)
                            state <= DUMP;
                    end
                end
                DUMP: begin
                    mse       <= mse_next;
                    mse_valid <= 1'b1;
                    win_cnt   <= win_cnt + 1'b1;
                    if (mse_next < mse_thresh) begin
                        below_cnt <= below_inc;
                        above_cnt <= '0;
                        if (below_inc == BW'(CONV_CNT))
                            converged <= 1'b1;
                    end else begin
                        above_cnt <= above_inc;
                        below_cnt <= '0;
                        if (above_inc == DW'(DIV_CNT))
                            converged <= 1'b0;
                    end
                    // A square landing during DUMP opens the next window.
                    acc     <= sq_valid ? ACC_W'(sq) : '0;
                    smp_cnt <= sq_valid ? LOG2_WIN'(1) : '0;
                    state   <= ACCUM;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LMS_PEAK_HOLD_EN
    logic [ERR_WIDTH-1:0] abs_q;
    logic [ERR_WIDTH-1:0] peak;
    logic [ERR_WIDTH-1:0] peak_max;

    assign peak_max = (abs_q > peak) ? abs_q : peak;

    // Magnitude rides alongside the square so the peak shares the accumulator's window boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_q    <= '0;
            peak     <= '0;
            err_peak <= '0;
        end else if (!en || clear) begin
            abs_q <= '0;
            peak  <= '0;
        end else begin
            if (err_valid)
                abs_q <= abs_err;
            case (state)
                ACCUM: if (sq_valid) peak <= peak_max;
                DUMP: begin
                    err_peak <= peak;
                    peak     <= sq_valid ? abs_q : '0;
                end
                default: ;
            endcase
        end
    end
`else
    assign err_peak = '0;
`endif

endmodule

// File: tb/tb_lms_err_monitor.sv
// Scoreboard bench for lms_err_monitor: directed windows, expected results queued at issue time.
module tb_lms_err_monitor;

    localparam int EW = 14;
    localparam int L  = 4;
    localparam int SQ = 2*EW-1;

    logic                 clk = 1'b0;
    logic                 rst_n, en, clear, err_valid;
    logic signed [EW-1:0] err;
    logic [SQ-1:0]        mse_thresh, mse;
    logic                 mse_valid, converged;
    logic [15:0]          win_cnt;
    logic [EW-1:0]        err_peak;

    lms_err_monitor #(.ERR_WIDTH(EW), .LOG2_WIN(L), .CONV_CNT(4), .DIV_CNT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .err_valid(err_valid),
        .err(err), .mse_thresh(mse_thresh), .mse(mse), .mse_valid(mse_valid),
        .converged(converged), .win_cnt(win_cnt), .err_peak(err_peak)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [SQ-1:0] mse;
        logic          conv;
        logic [15:0]   win;
        logic [EW-1:0] peak;
        int            at;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          last_cyc = 0;
    logic [15:0] exp_win  = '0;

    function automatic logic [EW-1:0] pk(input int v);
`ifdef LMS_PEAK_HOLD_EN
        return EW'(v);
`else
        return '0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic samples(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            en = 1'b1; clear = 1'b0; err_valid = 1'b1; err = EW'(v);
        end
        last_cyc = cyc;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            err_valid = 1'b0; clear = 1'b0;
        end
    endtask

    task automatic expect_win(input int m, input logic c, input int p);
        exp_t e;
        exp_win++;
        e.mse  = SQ'(m);
        e.conv = c;
        e.win  = exp_win;
        e.peak = pk(p);
        e.at   = last_cyc + 3;
        sbq.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mse_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_mse_valid", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("mse", mse, e.mse);
                    check("converged", converged, e.conv);
                    check("win_cnt", win_cnt, e.win);
                    check("err_peak", err_peak, e.peak);
                    check("pulse_cycle", cyc, e.at);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0; en = 1'b0; clear = 1'b0; err_valid = 1'b0; err = '0;
        mse_thresh = '0;
        repeat (3) @(negedge clk);
        check("rst_mse", mse, 0);
        check("rst_mse_valid", mse_valid, 0);
        check("rst_converged", converged, 0);
        check("rst_win_cnt", win_cnt, 0);
        check("rst_err_peak", err_peak, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        gap(2);

        samples(100, 16);   expect_win(10000, 1'b0, 100);
        gap(6);
        samples(-8192, 16); expect_win(67108864, 1'b0, 8192);
        gap(6);

        mse_thresh = 1000;
        for (int w = 0; w < 4; w++) begin
            samples(10, 16); expect_win(100, (w == 3), 10);
        end
        samples(100, 16); expect_win(10000, 1'b1, 100);
        samples(100, 16); expect_win(10000, 1'b0, 100);
        gap(6);

        for (int w = 0; w < 3; w++) begin
            samples(5, 16); expect_win(25, 1'b0, 5);
        end
        gap(6);

        samples(3, 7);
        @(posedge clk); #1;
        clear = 1'b1; err_valid = 1'b1; err = EW'(50);
        samples(3, 16); expect_win(9, 1'b0, 3);
        gap(6);

        samples(7, 9);
        @(posedge clk); #1;
        en = 1'b0; err_valid = 1'b1; err = EW'(7);
        gap(6);
        @(negedge clk);
        check("held_mse", mse, 9);
        check("held_win_cnt", win_cnt, 12);
        samples(2, 16); expect_win(4, 1'b0, 2);
        gap(2);

        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        gap(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
